// File: rtl/serial_adder_4bit.sv
// Bit-serial add/subtract unit: latches operands on start, resolves one bit per
// clock LSB first, and presents a registered result plus flags with a done pulse.
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             carry_d;
    logic [WIDTH-1:0] res_sh_d;

    // Full adder built as two half adders with their carries ORed.
    assign ha1_s    = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_c    = a_sh_q[0] & b_sh_q[0];
    assign ha2_s    = ha1_s ^ carry_q;
    assign ha2_c    = ha1_s & carry_q;
    assign carry_d  = ha1_c | ha2_c;
    assign res_sh_d = {ha2_s, res_sh_q[WIDTH-1:1]};

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        // Subtract as a + ~b + 1: invert b and seed the carry with 1.
                        b_sh_q  <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sh_q <= res_sh_d;
                    carry_q  <= carry_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // carry_q is the carry into the MSB on this final bit.
                        result_q    <= res_sh_d;
                        carry_out_q <= carry_d;
                        overflow_q  <= carry_q ^ carry_d;
                        zero_q      <= (res_sh_d == '0);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Directed bench for serial_adder_4bit: reset, add/sub flag cases, back-to-back,
// ignored start while busy, and reset mid-operation.
module tb_serial_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op_sub;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       carry_out;
    logic       overflow;
    logic       zero;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit overlap_seen = 1'b0;

    serial_adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until done is seen, up to max_cycles.
    task automatic wait_done(input int max_cycles, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < max_cycles && !seen) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic sub);
        a = av; b = bv; op_sub = sub; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic [3:0] er, input logic ec,
                               input logic eo, input logic ez);
        total_cnt++;
        if ({result, carry_out, overflow, zero} !== {er, ec, eo, ez})
            $display("FAIL %s: got result=%b c=%b v=%b z=%b, want result=%b c=%b v=%b z=%b",
                     name, result, carry_out, overflow, zero, er, ec, eo, ez);
        else pass_cnt++;
    endtask

    task automatic check_latency(input string name, input int n, input bit seen, input int exp_n);
        total_cnt++;
        if (!seen || n !== exp_n)
            $display("FAIL %s: done seen=%0d after %0d cycles, want done after %0d", name, seen, n, exp_n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        int dones;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, result, carry_out, overflow, zero} !== 9'b0)
            $display("FAIL reset_outputs: got busy=%b done=%b result=%b c=%b v=%b z=%b, want all 0",
                     busy, done, result, carry_out, overflow, zero);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL reset_idle: got %0d busy/done cycles, want 0", dones);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int n; bit seen;
        issue(4'b0111, 4'b1001, 1'b0);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL add_busy: got busy=%b, want 1", busy);
        else pass_cnt++;
        wait_done(20, n, seen);
        check_latency("add_wrap_latency", n, seen, 4);
        check_flags("add_wrap", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL done_width: got done=%b one cycle later, want 0", done);
        else pass_cnt++;
        issue(4'b0101, 4'b0100, 1'b0);
        wait_done(20, n, seen);
        check_latency("add_ovf_latency", n, seen, 4);
        check_flags("add_ovf", 4'b1001, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n; bit seen;
        tick();
        issue(4'b0011, 4'b0101, 1'b1);
        wait_done(20, n, seen);
        check_latency("sub_latency", n, seen, 4);
        check_flags("sub_borrow", 4'b1110, 1'b0, 1'b0, 1'b0);
        // Reassert start in the done cycle.
        issue(4'b1000, 4'b0001, 1'b1);
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy, done);
        else pass_cnt++;
        check_flags("b2b_hold", 4'b1110, 1'b0, 1'b0, 1'b0);
        wait_done(20, n, seen);
        check_latency("b2b_latency", n + 1, seen, 5);
        check_flags("sub_ovf", 4'b0111, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        int dones;
        tick();
        issue(4'b0001, 4'b0010, 1'b0);
        tick();
        a = 4'b1111; b = 4'b1111; op_sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        total_cnt++;
        if (dones !== 1) $display("FAIL ignore_done_count: got %0d done pulses, want 1", dones);
        else pass_cnt++;
        check_flags("ignore_result", 4'b0011, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int dones; int n; bit seen;
        issue(4'b0110, 4'b0011, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({busy, done, result, carry_out, overflow, zero} !== 9'b0)
            $display("FAIL midreset_outputs: got busy=%b done=%b result=%b c=%b v=%b z=%b, want all 0",
                     busy, done, result, carry_out, overflow, zero);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL midreset_no_done: got %0d busy/done cycles, want 0", dones);
        else pass_cnt++;
        issue(4'b0010, 4'b0011, 1'b0);
        wait_done(20, n, seen);
        check_latency("fresh_latency", n, seen, 4);
        check_flags("fresh_op", 4'b0101, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_exclusive();
        total_cnt++;
        if (overlap_seen !== 1'b0) $display("FAIL busy_done_overlap: got overlap=1, want 0");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
